// File: rtl/sample_capture.sv
// Tick-paced sample capture: waits N ticks after start, captures din on every N-th tick
// until R samples are taken, and buffers them in a first-word-fall-through FIFO.
module sample_capture #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [DW-1:0] din,
  input  logic          start,
  input  logic [CW-1:0] skip,
  input  logic [CW-1:0] num,
  input  logic          abort,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [CW-1:0] samp_cnt_q, samp_cnt_d;
  logic          overflow_q, overflow_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          cap_evt;
  logic          push_ok;
  logic [CW-1:0] tick_cnt_inc;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop          = !fifo_empty && out_ready;
  assign tick_cnt_inc = tick_cnt_q + CW'(1);
  assign cap_evt      = (state_q == S_WAIT) && tick && (tick_cnt_inc == n_q);
  assign push_ok      = cap_evt && (!fifo_full || pop);

  assign wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop     ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    r_d        = r_q;
    tick_cnt_d = tick_cnt_q;
    samp_cnt_d = samp_cnt_q;
    overflow_d = overflow_q;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          n_d        = (skip == '0) ? CW'(1) : skip;
          r_d        = (num == '0) ? CW'(1) : num;
          tick_cnt_d = '0;
          samp_cnt_d = '0;
          overflow_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cap_evt) begin
          tick_cnt_d = '0;
          samp_cnt_d = samp_cnt_q + CW'(1);
          state_d    = S_CAPTURE;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_inc;
        end
      end
      S_CAPTURE: begin
        if (samp_cnt_q == r_q) begin
          state_d = S_IDLE;
          done    = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A dropped capture still consumes its sample slot; only the data is lost.
    if (cap_evt && fifo_full && !pop) overflow_d = 1'b1;

    if (abort) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      r_q        <= '0;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      r_q        <= r_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is left unreset; equal pointers mark it empty and out_data is masked to 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sample_capture.sv
// Scoreboard bench for sample_capture: a tick-counting reference model predicts captures,
// a negedge monitor compares every output and every popped FIFO word.
module tb_sample_capture;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic [DW-1:0] din;
  logic          start;
  logic [CW-1:0] skip;
  logic [CW-1:0] num;
  logic          abort;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  sample_capture #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .din      (din),
    .start    (start),
    .skip     (skip),
    .num      (num),
    .abort    (abort),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: run phase flags, ticks seen since last capture, samples taken,
  // and the queue of words the FIFO should deliver.
  bit            m_wait, m_cap, m_ovf;
  int            m_ticks, m_taken, m_n, m_r, occ;
  bit            m_pop, m_capev;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] pop_log[$];
  int            done_cnt;
  bit            mon_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_wait = 1'b0; m_cap = 1'b0; m_ovf = 1'b0;
      m_ticks = 0; m_taken = 0; occ = 0;
      exp_q.delete();
    end else begin
      m_pop   = (occ > 0) && out_ready;
      m_capev = m_wait && tick && (m_ticks + 1 == m_n);
      if (m_capev) begin
        if (occ < DEPTH || m_pop) begin
          exp_q.push_back(din);
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_pop) occ--;
      if (abort) begin
        m_wait = 1'b0;
        m_cap  = 1'b0;
      end else if (!m_wait && !m_cap) begin
        if (start) begin
          m_n = (skip == 0) ? 1 : int'(skip);
          m_r = (num == 0) ? 1 : int'(num);
          m_ticks = 0; m_taken = 0; m_ovf = 1'b0;
          m_wait = 1'b1;
        end
      end else if (m_wait) begin
        if (m_capev) begin
          m_ticks = 0;
          m_taken++;
          m_wait = 1'b0;
          m_cap  = 1'b1;
        end else if (tick) begin
          m_ticks++;
        end
      end else begin
        m_cap  = 1'b0;
        m_wait = (m_taken != m_r);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", out_valid, occ != 0);
      if (occ == 0) check("out_data_empty", out_data, 0);
      check("busy", busy, m_wait || m_cap);
      check("done", done, m_cap && (m_taken == m_r) && !abort);
      check("overflow", overflow, m_ovf);
      if (done) done_cnt++;
      if (out_valid && out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 1, 0);
        end else begin
          check("pop_data", out_data, exp_q.pop_front());
        end
        pop_log.push_back(out_data);
      end
    end
  end

  logic [DW-1:0] din_v;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int sk, input int nm, input int tper, input int rdy_pct,
                     input int ready_from, input int len, input bit tick_on_start,
                     input int abort_at, input int rst_at);
    for (int c = 0; c < len; c++) begin
      start = (c == 0);
      skip  = CW'(sk);
      num   = CW'(nm);
      tick  = (c == 0) ? tick_on_start : ((tper > 0) && (c % tper == 0));
      if (tick) begin
        din   = din_v;
        din_v = din_v + 8'd1;
      end else begin
        din = DW'($urandom);
      end
      out_ready = (c >= ready_from) && ($urandom_range(99) < rdy_pct);
      abort     = (c == abort_at);
      rst       = (c == rst_at);
      step();
    end
    start = 1'b0; tick = 1'b0; abort = 1'b0; rst = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain();
    tick = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 4) step();
    out_ready = 1'b0;
  endtask

  task automatic clear_log();
    pop_log.delete();
    done_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; din = '0; start = 1'b0; skip = '0; num = '0;
    abort = 1'b0; out_ready = 1'b0; din_v = '0; done_cnt = 0;
    repeat (3) step();
    mon_en = 1'b1;
    rst = 1'b0;
    step();
    check("reset_busy", busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_overflow", overflow, 0);
    check("reset_done", done, 0);

    // Basic: N=3, one sample, ticks every 4 cycles, din 10,11,12 -> captures 12.
    clear_log(); din_v = 8'd10;
    run(3, 1, 4, 100, 0, 20, 1'b0, -1, -1);
    check("basic_count", pop_log.size(), 1);
    if (pop_log.size() == 1) check("basic_value", pop_log[0], 12);
    check("basic_done", done_cnt, 1);
    check("basic_busy_low", busy, 0);

    // Repeat: N=2, R=3, ticks 20..25 -> captures on ticks 2,4,6 = 21,23,25.
    clear_log(); din_v = 8'd20;
    run(2, 3, 2, 100, 0, 20, 1'b0, -1, -1);
    check("repeat_count", pop_log.size(), 3);
    if (pop_log.size() == 3) begin
      check("repeat_s0", pop_log[0], 21);
      check("repeat_s1", pop_log[1], 23);
      check("repeat_s2", pop_log[2], 25);
    end
    check("repeat_done", done_cnt, 1);

    // Overflow: six captures into a 4-deep FIFO with no consumer.
    clear_log(); din_v = 8'd30;
    run(1, 6, 2, 0, 100, 20, 1'b0, -1, -1);
    check("ovf_flag", overflow, 1);
    check("ovf_done", done_cnt, 1);
    drain();
    check("ovf_count", pop_log.size(), 4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) check("ovf_value", pop_log[i], 30 + i);

    // Full FIFO with a pop on the 5th capture cycle: nothing dropped.
    clear_log(); din_v = 8'd40;
    run(1, 5, 2, 100, 10, 20, 1'b0, -1, -1);
    drain();
    check("fullpop_overflow", overflow, 0);
    check("fullpop_count", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++) check("fullpop_value", pop_log[i], 40 + i);

    // Abort mid-WAIT, then a fresh run.
    clear_log(); din_v = 8'd50;
    run(3, 2, 2, 100, 0, 10, 1'b0, 3, -1);
    check("abort_no_done", done_cnt, 0);
    check("abort_busy_low", busy, 0);
    clear_log(); din_v = 8'd60;
    run(2, 1, 2, 100, 0, 10, 1'b0, -1, -1);
    check("after_abort_count", pop_log.size(), 1);
    if (pop_log.size() == 1) check("after_abort_value", pop_log[0], 61);
    check("after_abort_done", done_cnt, 1);

    // Reset mid-run with samples buffered.
    clear_log(); din_v = 8'h80;
    run(1, 8, 2, 0, 100, 12, 1'b0, -1, 7);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);

    // skip=0/num=0 with a tick on the start cycle: captures the next tick only.
    clear_log(); din_v = 8'd70;
    run(0, 0, 3, 100, 0, 10, 1'b1, -1, -1);
    check("edge_count", pop_log.size(), 1);
    if (pop_log.size() == 1) check("edge_value", pop_log[0], 71);
    check("edge_done", done_cnt, 1);

    // Randomized runs against the model.
    for (int k = 0; k < 25; k++) begin
      din_v = DW'($urandom);
      run($urandom_range(4), $urandom_range(6), $urandom_range(3, 1), $urandom_range(100),
          0, 30 + $urandom_range(20), 1'($urandom_range(1)),
          ($urandom_range(3) == 0) ? int'($urandom_range(25, 2)) : -1, -1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    drain();
    check("final_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
